// File: rtl/conv_cfg_axil_master_pkg.sv
// Shared definitions for the convolution-controller configuration master:
// register map, register values, FSM state types and the write request payload.
package conv_cfg_axil_master_pkg;

  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned REG_OFF_W   = 16;

  // Controller register byte offsets
  localparam int unsigned REG_CTRL        = 0;
  localparam int unsigned REG_RESET       = 4;
  localparam int unsigned REG_WIDTH       = 16;
  localparam int unsigned REG_HEIGHT      = 20;
  localparam int unsigned REG_FILTER_BASE = 24;

  localparam logic [AXIL_DATA_W-1:0] CTRL_ENABLE = AXIL_DATA_W'(1);
  localparam logic [AXIL_DATA_W-1:0] SOFT_RESET  = AXIL_DATA_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADDR,
    ST_RESP,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    BEAT_IDLE,
    BEAT_ADDR,
    BEAT_RESP
  } beat_state_e;

  typedef struct packed {
    logic [REG_OFF_W-1:0]   offset;
    logic [AXIL_DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [REG_OFF_W-1:0] filter_offset(input int unsigned tap);
    return REG_OFF_W'(REG_FILTER_BASE + 4 * tap);
  endfunction

endpackage

// File: rtl/axil_write_beat.sv
// Single AXI4-Lite write transaction engine: independent AW/W handshakes,
// B response, and a per-write timeout that aborts the transaction.
module axil_write_beat
  import conv_cfg_axil_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   launch,
  input  wr_req_t                req,
  output logic                   addr_done_c,
  output logic                   resp_done_c,
  output logic                   timeout_c,
  output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [AXIL_DATA_W-1:0] m_axi_wdata,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  beat_state_e            phase_q, phase_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   awvalid_d, wvalid_d, bready_d;
  logic [ADDR_WIDTH-1:0]  awaddr_d;
  logic [AXIL_DATA_W-1:0] wdata_d;
  logic                   aw_hs, w_hs;

  assign aw_hs       = m_axi_awvalid & m_axi_awready;
  assign w_hs        = m_axi_wvalid & m_axi_wready;
  assign addr_done_c = (phase_q == BEAT_ADDR) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign resp_done_c = (phase_q == BEAT_RESP) & m_axi_bready & m_axi_bvalid;
  // A response arriving on the last allowed cycle still counts as success
  assign timeout_c   = (phase_q != BEAT_IDLE) & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) & ~resp_done_c;

  always_comb begin
    phase_d   = phase_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    awvalid_d = m_axi_awvalid;
    wvalid_d  = m_axi_wvalid;
    bready_d  = m_axi_bready;
    awaddr_d  = m_axi_awaddr;
    wdata_d   = m_axi_wdata;
    case (phase_q)
      BEAT_IDLE: begin
        if (launch) begin
          phase_d   = BEAT_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = ADDR_WIDTH'(req.offset);
          wdata_d   = req.data;
        end
      end
      BEAT_ADDR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (addr_done_c) begin
          phase_d  = BEAT_RESP;
          bready_d = 1'b1;
        end
      end
      BEAT_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (resp_done_c) begin
          bready_d = 1'b0;
          phase_d  = BEAT_IDLE;
        end
      end
      default: phase_d = BEAT_IDLE;
    endcase
    if (timeout_c) begin
      phase_d   = BEAT_IDLE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      phase_q       <= BEAT_IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
    end else begin
      phase_q       <= phase_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_wdata   <= wdata_d;
    end
  end

endmodule

// File: rtl/conv_cfg_axil_master.sv
// Hardware sequencer that programs the convolution controller over AXI4-Lite:
// optional soft reset, enable, frame size, then the filter taps.
module conv_cfg_axil_master
  import conv_cfg_axil_master_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SOFT_RESET_EN  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                  axi_clk,
  input  logic                                  axi_reset_n,
  input  logic                                  start,
  input  logic [31:0]                           cfg_width,
  input  logic [31:0]                           cfg_height,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*32-1:0] cfg_filter,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [ADDR_WIDTH-1:0]                 m_axi_awaddr,
  output logic                                  m_axi_awvalid,
  input  logic                                  m_axi_awready,
  output logic [DATA_WIDTH-1:0]                 m_axi_wdata,
  output logic                                  m_axi_wvalid,
  input  logic                                  m_axi_wready,
  input  logic                                  m_axi_bvalid,
  output logic                                  m_axi_bready
);

  localparam int unsigned TAPS       = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned NUM_WRITES = ((SOFT_RESET_EN != 0) ? 1 : 0) + 3 + TAPS;
  localparam int unsigned IDX_W      = $clog2(NUM_WRITES + 1);
  localparam int unsigned STEP_W     = IDX_W + 1;
  localparam int unsigned TAP_IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

  seq_state_e                         state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               busy_d, done_d, error_d;
  logic                               cfg_latch;
  logic [31:0]                        width_q, height_q;
  logic [TAPS-1:0][AXIL_DATA_W-1:0]   filter_q;
  logic [STEP_W-1:0]                  step;
  logic [TAP_IDX_W-1:0]               tap_idx;
  wr_req_t                            req;
  logic                               launch;
  logic                               addr_done_c, resp_done_c, timeout_c;

  assign launch = (state_q == ST_LOAD);

  // Register table: step 0 is the soft reset, skipped by offsetting the index
  always_comb begin
    step    = STEP_W'(idx_q) + STEP_W'((SOFT_RESET_EN != 0) ? 0 : 1);
    tap_idx = TAP_IDX_W'(step - STEP_W'(4));
    req     = '0;
    case (step)
      STEP_W'(0): begin
        req.offset = REG_OFF_W'(REG_RESET);
        req.data   = SOFT_RESET;
      end
      STEP_W'(1): begin
        req.offset = REG_OFF_W'(REG_CTRL);
        req.data   = CTRL_ENABLE;
      end
      STEP_W'(2): begin
        req.offset = REG_OFF_W'(REG_WIDTH);
        req.data   = width_q;
      end
      STEP_W'(3): begin
        req.offset = REG_OFF_W'(REG_HEIGHT);
        req.data   = height_q;
      end
      default: begin
        req.offset = filter_offset(32'(tap_idx));
        req.data   = filter_q[tap_idx];
      end
    endcase
  end

  // Sequencing FSM next state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy;
    done_d    = 1'b0;
    error_d   = error;
    cfg_latch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          idx_d     = '0;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          cfg_latch = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_ADDR;
      ST_ADDR: begin
        if (timeout_c) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else if (addr_done_c) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (timeout_c) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else if (resp_done_c) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_q + IDX_W'(1) == IDX_W'(NUM_WRITES)) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      width_q  <= '0;
      height_q <= '0;
      filter_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
      if (cfg_latch) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        filter_q <= cfg_filter;
      end
    end
  end

  axil_write_beat #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_beat (
    .axi_clk       (axi_clk),
    .axi_reset_n   (axi_reset_n),
    .launch        (launch),
    .req           (req),
    .addr_done_c   (addr_done_c),
    .resp_done_c   (resp_done_c),
    .timeout_c     (timeout_c),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

endmodule
